present_round_ctrl: RTL and testbench

//  Sequencing controller for the round-based, area-optimised PRESENT core.

---
 rtl/present_pkg.sv | 15 +
 rtl/present_round_ctrl.sv | 61 ++++++
 tb/tb_present_round_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/present_pkg.sv
// Shared constants and state encoding for the PRESENT round-sequencing controller.
package present_pkg;

  localparam int PRESENT_ROUNDS = 31;
  localparam int CNT_W          = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    OUTV  = 3'd4
  } state_t;

endpackage

// File: rtl/present_round_ctrl.sv
// Sequencer for the round-based PRESENT datapath: load, ROUNDS round cycles,
// final addRoundKey, then hold the result until the consumer acknowledges.
module present_round_ctrl
  import present_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS,
  parameter int CNT_W  = present_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             out_ack,
  output logic             ready,
  output logic             busy,
  output logic             ld_state,
  output logic             rnd_en,
  output logic [CNT_W-1:0] round_cnt,
  output logic             final_xor,
  output logic             out_valid
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_round;

  assign last_round = (cnt_q == CNT_W'(ROUNDS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = ROUND;
      ROUND:   if (last_round) state_d = FINAL;
      FINAL:   state_d = OUTV;
      // a start without an ack is dropped, not queued
      OUTV:    if (out_ack) state_d = start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // counter stops at ROUNDS so the key schedule never sees a wrapped index
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               cnt_q <= CNT_W'(1);
    else if (state_q == LOAD)                cnt_q <= CNT_W'(1);
    else if (state_q == ROUND && !last_round) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign ready     = (state_q == IDLE) || (state_q == OUTV);
  assign busy      = (state_q == LOAD) || (state_q == ROUND) || (state_q == FINAL);
  assign ld_state  = (state_q == LOAD);
  assign rnd_en    = (state_q == ROUND);
  assign final_xor = (state_q == FINAL);
  assign out_valid = (state_q == OUTV);
  assign round_cnt = cnt_q;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Randomized and directed check of two controller instances (31 and 4 rounds)
// against a cycle-count reference model.
module tb_present_round_ctrl;

  localparam int RA = 31;
  localparam int RB = 4;

  logic clk = 1'b0;
  logic reset, start, out_ack;

  logic       ready_a, busy_a, ld_a, rnd_a, fin_a, ov_a;
  logic [4:0] cnt_a;
  logic       ready_b, busy_b, ld_b, rnd_b, fin_b, ov_b;
  logic [4:0] cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  present_round_ctrl #(.ROUNDS(RA), .CNT_W(5)) dut_a (
    .clk(clk), .reset(reset), .start(start), .out_ack(out_ack),
    .ready(ready_a), .busy(busy_a), .ld_state(ld_a), .rnd_en(rnd_a),
    .round_cnt(cnt_a), .final_xor(fin_a), .out_valid(ov_a)
  );

  present_round_ctrl #(.ROUNDS(RB), .CNT_W(5)) dut_b (
    .clk(clk), .reset(reset), .start(start), .out_ack(out_ack),
    .ready(ready_b), .busy(busy_b), .ld_state(ld_b), .rnd_en(rnd_b),
    .round_cnt(cnt_b), .final_xor(fin_b), .out_valid(ov_b)
  );

  // Reference model: t = cycles since the start was accepted (0 = not running),
  // ov = result held, mc = counter value the key schedule should see.
  int t  [2];
  bit ov [2];
  int mc [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        t[i]  <= 0;
        ov[i] <= 1'b0;
        mc[i] <= 1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int r;
        r = (i == 0) ? RA : RB;
        if (t[i] == 0) begin
          if (start && (!ov[i] || out_ack)) begin
            t[i]  <= 1;
            ov[i] <= 1'b0;
          end else if (ov[i] && out_ack) begin
            ov[i] <= 1'b0;
          end
        end else begin
          if (t[i] == 1)      mc[i] <= 1;
          else if (t[i] <= r) mc[i] <= t[i];
          if (t[i] == r + 2) begin
            t[i]  <= 0;
            ov[i] <= 1'b1;
          end else begin
            t[i] <= t[i] + 1;
          end
        end
      end
    end
  end

  function automatic logic [10:0] model_vec(int i);
    int  r;
    bit  bz;
    r  = (i == 0) ? RA : RB;
    bz = (t[i] != 0);
    return {!bz, bz, t[i] == 1, (t[i] >= 2) && (t[i] <= r + 1), t[i] == r + 2,
            ov[i], 5'(mc[i])};
  endfunction

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [10:0] act [2];
      logic [10:0] exp_v;
      act[0] = {ready_a, busy_a, ld_a, rnd_a, fin_a, ov_a, cnt_a};
      act[1] = {ready_b, busy_b, ld_b, rnd_b, fin_b, ov_b, cnt_b};
      for (int i = 0; i < 2; i++) begin
        exp_v = model_vec(i);
        checks++;
        if (act[i] !== exp_v) begin
          errors++;
          $display("FAIL model_dut%0d t=%0t actual=%b required=%b (rdy,bsy,ld,rnd,fin,ov,cnt)",
                   i, $time, act[i], exp_v);
        end
        checks++;
        if (($countones(act[i][8:6]) > 1) || (act[i][10] && act[i][9])) begin
          errors++;
          $display("FAIL exclusive_dut%0d t=%0t actual=%b required=one-hot-or-zero strobes, not ready&busy",
                   i, $time, act[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in cycle 0 and walk both instances through a complete run.
  task automatic run_full();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_ld_c1", ld_a, 1);
    chk("a_ready_c1", ready_a, 0);
    chk("b_ld_c1", ld_b, 1);
    for (int cyc = 2; cyc <= 34; cyc++) begin
      tick();
      start = (cyc == 10) ? 1'b1 : 1'b0;
      if (cyc <= 32) begin
        chk("a_rnd", rnd_a, 1);
        chk("a_cnt", cnt_a, cyc - 1);
      end
      if (cyc == 33) chk("a_final", fin_a, 1);
      if (cyc == 34) chk("a_outv", ov_a, 1);
      if (cyc <= 5) chk("b_cnt", cnt_b, cyc - 1);
      if (cyc == 6) chk("b_final", fin_b, 1);
      if (cyc == 7) chk("b_outv", ov_b, 1);
    end
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    start   = 1'b0;
    out_ack = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;
    chk("reset_ready", ready_a, 1);
    chk("reset_cnt", cnt_a, 1);
    chk("reset_busy", busy_a, 0);
    reset = 1'b0;

    // full sequence, with a start pulse during ROUND that must be ignored
    run_full();

    // held result ignores start without ack
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      tick();
      chk("hold_ov", ov_a, 1);
      chk("hold_ld", ld_a, 0);
      chk("hold_cnt", cnt_a, 31);
    end

    // ack and start together: back-to-back run
    out_ack = 1'b1;
    start   = 1'b1;
    tick();
    out_ack = 1'b0;
    start   = 1'b0;
    chk("b2b_ld", ld_a, 1);
    chk("b2b_ready", ready_a, 0);
    tick();
    chk("b2b_cnt", cnt_a, 1);
    chk("b2b_ready2", ready_a, 0);

    // asynchronous reset mid-cycle at round 17
    n = 0;
    while (cnt_a != 5'd17 && n < 100) begin
      tick();
      n++;
    end
    chk("reach_cnt17", cnt_a, 17);
    #2 reset = 1'b1;
    #1;
    chk("arst_ready", ready_a, 1);
    chk("arst_cnt", cnt_a, 1);
    chk("arst_rnd", rnd_a, 0);
    chk("arst_busy", busy_a, 0);
    tick();
    reset = 1'b0;
    run_full();

    // randomized traffic with occasional mid-cycle resets
    for (int k = 0; k < 3000; k++) begin
      tick();
      reset   = 1'b0;
      start   = ($urandom_range(0, 7) == 0);
      out_ack = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 399) == 0) #2 reset = 1'b1;
    end
    tick();
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
